rdm_stream_reader: RTL and testbench
====================================

RDM_STREAM_READER -- requirements
Module: rdm_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 96, width of one soft-bit buffer word.
REQ-002 SHALL have parameter ADDR_W, default 16, width of the buffer read address.
REQ-003 SHALL have parameter RD_LAT, default 2, buffer read latency in cycles, legal range 1..4.
REQ-004 SHALL have port i_core_clk  in  1  core clock, all logic on the rising edge.
REQ-005 SHALL have port i_rx_rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_rx_fsm_rstn  in  1  FSM soft reset, asynchronous, active-low, same effect as i_rx_rstn.
REQ-007 SHALL have port i_start  in  1  single-cycle request to start one user's stream.
REQ-008 SHALL have port i_e_size  in  14  number of words to emit.
REQ-009 SHALL have port i_ncb_size  in  16  circular-buffer length in words.
REQ-010 SHALL have port i_k0  in  16  start offset inside the circular buffer.
REQ-011 SHALL have port i_base_addr  in  ADDR_W  buffer address of circular-buffer word 0.
REQ-012 SHALL have port i_user_index  in  4  user tag for the stream.
REQ-013 SHALL have port o_rd_en  out  1  buffer read strobe.
REQ-014 SHALL have port o_rd_addr  out  ADDR_W  buffer read address.
REQ-015 SHALL have port i_rd_data  in  DATA_W  buffer data, valid RD_LAT cycles after o_rd_en.
REQ-016 SHALL have port o_valid  out  1  output word valid.
REQ-017 SHALL have port i_ready  in  1  consumer ready.
REQ-018 SHALL have port o_data  out  DATA_W  output word.
REQ-019 SHALL have port o_last  out  1  marks the i_e_size-th word.
REQ-020 SHALL have port o_user_index  out  4  latched i_user_index.
REQ-021 SHALL have port o_busy  out  1  high from the cycle after an accepted i_start until o_done.
REQ-022 SHALL have port o_done  out  1  single-cycle completion pulse.

Function
REQ-023 SHALL implement the states IDLE, FETCH, DRAIN and DONE.
- IDLE -> FETCH: on i_start with i_e_size!=0 and i_ncb_size!=0.
- FETCH -> DRAIN: once i_e_size reads have been issued.
- DRAIN -> DONE: when the last word is accepted.
- DONE -> IDLE: always, after 1 cycle.
REQ-024 SHALL, in IDLE, latch i_e_size, i_ncb_size, i_k0, i_base_addr and i_user_index on an accepted i_start.
REQ-025 SHALL ignore i_start outside IDLE, and in IDLE when i_e_size==0 or i_ncb_size==0; no o_done is produced in either case.
REQ-026 SHALL use circular index 0 for the first read when i_k0>=i_ncb_size, and i_k0 otherwise.
REQ-027 SHALL form o_rd_addr as base + index, modulo 2^ADDR_W.
REQ-028 SHALL increment the index by 1 per issued read and wrap it from ncb-1 to 0; i_e_size > i_ncb_size repeats the buffer.
REQ-029 SHALL hold an internal skid FIFO of RD_LAT+2 words.
REQ-030 SHALL issue a read only when (words in flight + FIFO occupancy) < RD_LAT+2; the FIFO therefore never overflows.
REQ-031 SHALL emit words in read order, and SHALL drive o_data/o_last from the FIFO head with o_valid = FIFO not empty.
REQ-032 SHALL count a transfer on o_valid && i_ready; o_data and o_last SHALL stay stable while o_valid && !i_ready.
REQ-033 SHALL give a first-word latency of RD_LAT+1 cycles from the cycle after i_start, with i_ready held high.
REQ-034 SHALL sustain 1 word per cycle while i_ready is high.
REQ-035 SHALL assert o_last on exactly one transfer, the i_e_size-th.
REQ-036 SHALL assert o_done for the 1 cycle in DONE, with o_busy low in that cycle.

Reset
REQ-037 SHALL, on either reset, return to IDLE immediately, including mid-stream.
REQ-038 SHALL, on either reset, empty the FIFO, discard in-flight reads, and drive o_rd_en, o_valid, o_last, o_busy and o_done to 0, and o_rd_addr, o_data and o_user_index to 0.
REQ-039 SHALL drop buffer data returning after a reset.

Configuration
REQ-040 SHALL compile in a stall counter when RDM_STREAM_STATS_EN is defined: port o_stall_cnt out 16.
- Counts cycles with o_valid && !i_ready.
- Clears on an accepted i_start and on reset.
- Saturates at 0xFFFF.
REQ-041 SHALL omit o_stall_cnt and its logic when RDM_STREAM_STATS_EN is undefined; all other behaviour is unchanged.

Verification
REQ-042 SHALL cover: e=8, ncb=100, k0=10, base=0x200, ready=1 -> addresses 0x20A..0x211, 8 words in 8 consecutive cycles, o_last on word 8, o_done once.
REQ-043 SHALL cover: e=6, ncb=5, k0=3, base=0 -> read indices 3,4,0,1,2,3.
REQ-044 SHALL cover: e=20, i_ready toggled 1-of-3 cycles -> no word lost or duplicated, o_data stable during stalls, and occupancy never above RD_LAT+2.
REQ-045 SHALL cover: k0=120, ncb=100 -> first index 0; and i_start with e=0 -> stays IDLE, no o_done.
REQ-046 SHALL cover: i_rx_fsm_rstn pulsed after word 3 of 10 -> outputs 0 next cycle; a new i_start then yields a clean stream with no stale data.
REQ-047 SHALL cover, with RDM_STREAM_STATS_EN defined: 7 stall cycles in one stream -> o_stall_cnt=7.

Source files
------------

// File: rtl/rdm_stream_reader_if.sv
// Buffer-read port and output-stream handshake of rdm_stream_reader.
// The master modport is the reader side; the slave modport is buffer plus consumer.
interface rdm_stream_reader_if #(
    parameter int DATA_W = 96,
    parameter int ADDR_W = 16
);
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] i_rd_data;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic [3:0]        o_user_index;

    modport master (
        output o_rd_en, o_rd_addr, o_valid, o_data, o_last, o_user_index,
        input  i_rd_data, i_ready
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_valid, o_data, o_last, o_user_index,
        output i_rd_data, i_ready
    );
endinterface

// File: rtl/rdm_stream_reader.sv
// Streams i_e_size words out of a circular soft-bit buffer through a skid FIFO.
// Define RDM_STREAM_STATS_EN to add the o_stall_cnt back-pressure counter.
module rdm_stream_reader #(
    parameter int DATA_W = 96,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              i_core_clk,
    input  logic              i_rx_rstn,
    input  logic              i_rx_fsm_rstn,
    input  logic              i_start,
    input  logic [13:0]       i_e_size,
    input  logic [15:0]       i_ncb_size,
    input  logic [15:0]       i_k0,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [3:0]        i_user_index,
    output logic              o_busy,
    output logic              o_done,
`ifdef RDM_STREAM_STATS_EN
    output logic [15:0]       o_stall_cnt,
`endif
    rdm_stream_reader_if.master bus
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       ncb_q, ncb_d;
    logic [15:0]       idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        user_q, user_d;
    logic [13:0]       rd_left_q, rd_left_d;
    logic [13:0]       out_left_q, out_left_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [DATA_W-1:0] mem_q [2**PTR_W];

    logic rst_n;
    logic start_ok, rd_en, ret, valid, pop;

    // Both resets have identical effect, so they are merged into one async clear.
    assign rst_n = i_rx_rstn & i_rx_fsm_rstn;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid = (count_q != '0);
    assign pop   = valid && bus.i_ready;
    assign ret   = pipe_q[RD_LAT-1];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        ncb_d      = ncb_q;
        idx_d      = idx_q;
        base_d     = base_q;
        user_d     = user_q;
        rd_left_d  = rd_left_q;
        out_left_d = pop ? out_left_q - 14'd1 : out_left_q;
        start_ok   = 1'b0;
        rd_en      = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start && i_e_size != '0 && i_ncb_size != '0) begin
                    start_ok   = 1'b1;
                    ncb_d      = i_ncb_size;
                    idx_d      = (i_k0 >= i_ncb_size) ? '0 : i_k0;
                    base_d     = i_base_addr;
                    user_d     = i_user_index;
                    rd_left_d  = i_e_size;
                    out_left_d = i_e_size;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                o_busy = 1'b1;
                // Every issued read has a reserved FIFO slot, so the FIFO cannot overflow.
                rd_en  = (inflight_q + count_q) < DEPTH_C;
                if (rd_en) begin
                    idx_d     = (idx_q == ncb_q - 16'd1) ? '0 : idx_q + 16'd1;
                    rd_left_d = rd_left_q - 14'd1;
                    if (rd_left_q == 14'd1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (pop && out_left_q == 14'd1) state_d = S_DONE;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pipe_d     = pipe_q << 1;
        pipe_d[0]  = rd_en;
        inflight_d = inflight_q + CNT_W'(rd_en) - CNT_W'(ret);
        count_d    = count_q + CNT_W'(ret) - CNT_W'(pop);
        wr_ptr_d   = ret ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge i_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ncb_q      <= '0;
            idx_q      <= '0;
            base_q     <= '0;
            user_q     <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            ncb_q      <= ncb_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            user_q     <= user_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pipe_q     <= pipe_d;
        end
    end

    // NOTE: FIFO storage has no reset; the cleared pointers and count make stale entries unreachable.
    always_ff @(posedge i_core_clk) begin
        if (ret) mem_q[wr_ptr_q] <= bus.i_rd_data;
    end

    assign bus.o_rd_en      = rd_en;
    assign bus.o_rd_addr    = rd_en ? base_q + ADDR_W'(idx_q) : '0;
    assign bus.o_valid      = valid;
    assign bus.o_data       = valid ? mem_q[rd_ptr_q] : '0;
    assign bus.o_last       = valid && (out_left_q == 14'd1);
    assign bus.o_user_index = user_q;

`ifdef RDM_STREAM_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge i_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (valid && !bus.i_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_rdm_stream_reader.sv
// Directed bench for rdm_stream_reader: buffer model with RD_LAT latency, stream monitor,
// hand-computed address/data expectations; stall-counter checks when RDM_STREAM_STATS_EN is defined.
module tb_rdm_stream_reader;
    localparam int DATA_W = 96;
    localparam int ADDR_W = 16;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = RD_LAT + 2;

    logic              i_core_clk = 1'b0;
    logic              i_rx_rstn;
    logic              i_rx_fsm_rstn;
    logic              i_start;
    logic [13:0]       i_e_size;
    logic [15:0]       i_ncb_size;
    logic [15:0]       i_k0;
    logic [ADDR_W-1:0] i_base_addr;
    logic [3:0]        i_user_index;
    logic              o_busy;
    logic              o_done;
`ifdef RDM_STREAM_STATS_EN
    logic [15:0]       o_stall_cnt;
`endif

    rdm_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rdm_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .i_core_clk    (i_core_clk),
        .i_rx_rstn     (i_rx_rstn),
        .i_rx_fsm_rstn (i_rx_fsm_rstn),
        .i_start       (i_start),
        .i_e_size      (i_e_size),
        .i_ncb_size    (i_ncb_size),
        .i_k0          (i_k0),
        .i_base_addr   (i_base_addr),
        .i_user_index  (i_user_index),
        .o_busy        (o_busy),
        .o_done        (o_done),
`ifdef RDM_STREAM_STATS_EN
        .o_stall_cnt   (o_stall_cnt),
`endif
        .bus           (bus)
    );

    always #5 i_core_clk = ~i_core_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc;
    int done_cnt;
    int done_cyc;
    int stall_seen;
    int max_out;

    logic [ADDR_W-1:0] rd_log[$];
    logic [DATA_W-1:0] data_log[$];
    logic              last_log[$];
    int                xfer_cyc[$];
    logic [ADDR_W-1:0] exp_addr[$];

    logic              stall_pending = 1'b0;
    logic [DATA_W-1:0] stall_data;
    logic              stall_last;

    logic              lat_en   [RD_LAT+1];
    logic [ADDR_W-1:0] lat_addr [RD_LAT+1];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, a, ~a, a ^ 16'h5A5A, 16'h1234, a};
    endfunction

    function automatic logic ready_for(input int mode, input int rel);
        case (mode)
            1:       return (rel % 3) == 0;
            2:       return rel > 10;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge i_core_clk) cyc <= cyc + 1;

    // Buffer model: a read seen in cycle n returns its word during cycle n+RD_LAT.
    always @(negedge i_core_clk) begin
        for (int k = RD_LAT; k > 0; k--) begin
            lat_en[k]   = lat_en[k-1];
            lat_addr[k] = lat_addr[k-1];
        end
        lat_en[0]     = bus.o_rd_en;
        lat_addr[0]   = bus.o_rd_addr;
        bus.i_rd_data = lat_en[RD_LAT] ? mem_word(lat_addr[RD_LAT]) : {3{32'hBAD0_BAD0}};
    end

    always @(negedge i_core_clk) begin
        if (bus.o_rd_en) rd_log.push_back(bus.o_rd_addr);
        if (bus.o_valid && bus.i_ready) begin
            data_log.push_back(bus.o_data);
            last_log.push_back(bus.o_last);
            xfer_cyc.push_back(cyc);
        end
        if (stall_pending) begin
            check("stall_valid_held", bus.o_valid, 1'b1);
            check("stall_data_held", bus.o_data, stall_data);
            check("stall_last_held", bus.o_last, stall_last);
        end
        stall_pending = bus.o_valid && !bus.i_ready;
        stall_data    = bus.o_data;
        stall_last    = bus.o_last;
        if (stall_pending) stall_seen++;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_low_in_done", o_busy, 1'b0);
        end
        if (rd_log.size() - data_log.size() > max_out) max_out = rd_log.size() - data_log.size();
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, bus.o_rd_en, 1'b0);
        check({tag, "_rd_addr"}, bus.o_rd_addr, '0);
        check({tag, "_valid"}, bus.o_valid, 1'b0);
        check({tag, "_data"}, bus.o_data, '0);
        check({tag, "_last"}, bus.o_last, 1'b0);
        check({tag, "_user"}, bus.o_user_index, 4'd0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_done"}, o_done, 1'b0);
    endtask

    // Runs one stream against exp_addr; mode selects the i_ready pattern,
    // abort_after>0 pulses i_rx_fsm_rstn once that many words have been transferred.
    task automatic run_stream(input logic [13:0] e, input logic [15:0] ncb, input logic [15:0] k0,
                              input logic [ADDR_W-1:0] base, input logic [3:0] user,
                              input int mode, input int abort_after);
        bit aborted = 1'b0;
        rd_log.delete();
        data_log.delete();
        last_log.delete();
        xfer_cyc.delete();
        done_cnt   = 0;
        done_cyc   = 0;
        stall_seen = 0;
        max_out    = 0;
        @(posedge i_core_clk); #1;
        i_start      = 1'b1;
        i_e_size     = e;
        i_ncb_size   = ncb;
        i_k0         = k0;
        i_base_addr  = base;
        i_user_index = user;
        bus.i_ready  = 1'b1;
        start_cyc    = cyc;
        for (int rel = 1; rel <= 400; rel++) begin
            @(posedge i_core_clk); #1;
            i_start      = (mode == 1 && rel == 5);
            i_e_size     = 14'h3FFF;
            i_ncb_size   = 16'd3;
            i_k0         = 16'd1;
            i_base_addr  = ADDR_W'(16'hDEAD);
            i_user_index = ~user;
            bus.i_ready  = ready_for(mode, rel);
            @(negedge i_core_clk); #1;
            if (rel == 1) check("busy_after_start", o_busy, 1'b1);
            if (abort_after != 0 && data_log.size() == abort_after) begin
                @(posedge i_core_clk); #1;
                i_rx_fsm_rstn = 1'b0;
                #1;
                check_idle_outputs("fsm_rst");
                @(negedge i_core_clk);
                i_rx_fsm_rstn = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (done_cnt != 0) break;
        end
        i_start = 1'b0;
        if (aborted) return;
        check("done_seen", done_cnt, 1);
        bus.i_ready = 1'b1;
        repeat (3) @(posedge i_core_clk);
        #1;
        check("done_once", done_cnt, 1);
        check("idle_busy_low", o_busy, 1'b0);
        check("rd_count", rd_log.size(), exp_addr.size());
        check("xfer_count", data_log.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < rd_log.size())
                check($sformatf("rd_addr[%0d]", i), rd_log[i], exp_addr[i]);
            if (i < data_log.size()) begin
                check($sformatf("data[%0d]", i), data_log[i], mem_word(exp_addr[i]));
                check($sformatf("last[%0d]", i), last_log[i], i == exp_addr.size() - 1);
            end
        end
        check("user_index", bus.o_user_index, user);
        check("occupancy_bound", max_out <= DEPTH, 1'b1);
    endtask

    task automatic idle_start(input logic [13:0] e, input logic [15:0] ncb, input string tag);
        rd_log.delete();
        done_cnt = 0;
        @(posedge i_core_clk); #1;
        i_start     = 1'b1;
        i_e_size    = e;
        i_ncb_size  = ncb;
        i_k0        = 16'd0;
        i_base_addr = ADDR_W'(16'h0123);
        @(posedge i_core_clk); #1;
        i_start = 1'b0;
        repeat (8) @(posedge i_core_clk);
        #1;
        check({tag, "_no_reads"}, rd_log.size(), 0);
        check({tag, "_no_done"}, done_cnt, 0);
        check({tag, "_not_busy"}, o_busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k <= RD_LAT; k++) begin
            lat_en[k]   = 1'b0;
            lat_addr[k] = '0;
        end
        i_rx_rstn     = 1'b0;
        i_rx_fsm_rstn = 1'b1;
        i_start       = 1'b0;
        i_e_size      = '0;
        i_ncb_size    = '0;
        i_k0          = '0;
        i_base_addr   = '0;
        i_user_index  = '0;
        bus.i_ready   = 1'b1;
        #2;
        check_idle_outputs("reset");
`ifdef RDM_STREAM_STATS_EN
        check("reset_stall_cnt", o_stall_cnt, 16'd0);
`endif
        repeat (3) @(posedge i_core_clk);
        #1;
        i_rx_rstn = 1'b1;

        // Full-rate stream: 0x20A..0x211, one word per cycle.
        exp_addr = {16'h020A, 16'h020B, 16'h020C, 16'h020D, 16'h020E, 16'h020F, 16'h0210, 16'h0211};
        run_stream(14'd8, 16'd100, 16'd10, 16'h0200, 4'd5, 0, 0);
        if (xfer_cyc.size() == 8) begin
            check("first_word_latency", xfer_cyc[0] - (start_cyc + 1), RD_LAT + 1);
            check("burst_span", xfer_cyc[7] - xfer_cyc[0], 7);
            check("done_after_last", done_cyc - xfer_cyc[7], 1);
        end

        // Circular wrap: indices 3,4,0,1,2,3.
        exp_addr = {16'd3, 16'd4, 16'd0, 16'd1, 16'd2, 16'd3};
        run_stream(14'd6, 16'd5, 16'd3, 16'h0000, 4'd9, 0, 0);

        // Back-pressure 1-of-3 with a start pulse while busy: indices (2+i) mod 7 at 0x1000.
        exp_addr.delete();
        for (int i = 0; i < 20; i++) exp_addr.push_back(16'h1000 + 16'((2 + i) % 7));
        run_stream(14'd20, 16'd7, 16'd2, 16'h1000, 4'd3, 1, 0);
        check("stalls_exercised", stall_seen > 0, 1'b1);

        // k0 beyond the buffer starts at index 0.
        exp_addr = {16'h0050, 16'h0051, 16'h0052};
        run_stream(14'd3, 16'd100, 16'd120, 16'h0050, 4'd1, 0, 0);

        // k0 equal to ncb starts at 0; address wraps modulo 2^16.
        exp_addr = {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        run_stream(14'd4, 16'd4, 16'd4, 16'hFFFE, 4'd2, 0, 0);

        idle_start(14'd0, 16'd10, "e_zero");
        idle_start(14'd5, 16'd0, "ncb_zero");

        // Soft reset after word 3 of 10, then a fresh stream with no stale words.
        exp_addr.delete();
        run_stream(14'd10, 16'd50, 16'd0, 16'h0300, 4'd7, 0, 3);
        check("rst_words_before", data_log.size(), 3);
        check("rst_no_done", done_cnt, 0);
        exp_addr = {16'h0401, 16'h0402, 16'h0403, 16'h0404};
        run_stream(14'd4, 16'd10, 16'd1, 16'h0400, 4'd11, 0, 0);

`ifdef RDM_STREAM_STATS_EN
        // Ready low for 10 cycles after start; valid appears on the 4th, so 7 stalls.
        exp_addr = {16'h0700, 16'h0701, 16'h0702, 16'h0703, 16'h0704, 16'h0705};
        run_stream(14'd6, 16'd16, 16'd0, 16'h0700, 4'd4, 2, 0);
        check("stall_cnt", o_stall_cnt, 16'd7);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
